// File: rtl/dsi_pkg.sv
// rtl/dsi_pkg.sv - shared lane-count default and distributor state encoding
package dsi_pkg;

    localparam int LANES_MAX_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_IDLE     = 3'd1,
        ST_LOAD     = 3'd2,
        ST_START    = 3'd3,
        ST_SEND     = 3'd4,
        ST_DRAIN    = 3'd5
    } dsi_state_t;

endpackage

// File: rtl/dsi_lanes_distributor.sv
// rtl/dsi_lanes_distributor.sv - splits upstream beats into per-lane bytes for DSI data lanes
module dsi_lanes_distributor
    import dsi_pkg::*;
#(
    parameter int LANES_MAX = LANES_MAX_DEFAULT
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    input  logic                   lines_enable,
    input  logic [1:0]             lanes_number,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*LANES_MAX-1:0] in_data,
    input  logic                   in_last,
    input  logic                   in_lp,
    output logic                   lane_enable,
    output logic                   lane_mode_lp,
    output logic [LANES_MAX-1:0]   lane_start_rqst,
    output logic [LANES_MAX-1:0]   lane_fin_rqst,
    output logic [8*LANES_MAX-1:0] lane_data,
    input  logic [LANES_MAX-1:0]   lane_data_rqst,
    input  logic [LANES_MAX-1:0]   lane_active,
    output logic                   busy,
    output logic                   underflow_err,
    output logic                   sync_err
);

    dsi_state_t             state;
    logic [8*LANES_MAX-1:0] hold_data;
    logic                   hold_last;
    logic                   hold_valid;
    logic                   last_seen;
    logic [LANES_MAX-1:0]   mask;
    logic                   lp_mode;
    logic [LANES_MAX-1:0]   mask_next;
    logic                   send;
    logic                   consume;
    logic                   accept;
    logic                   shutdown;

    always_comb begin
        mask_next = '0;
        for (int i = 0; i < LANES_MAX; i++) begin
            mask_next[i] = (i <= int'(lanes_number));
        end
    end

    assign send     = (state == ST_SEND);
    assign consume  = send & lane_data_rqst[0] & hold_valid;
    // Losing the enable before SEND abandons the packet; SEND/DRAIN always complete.
    assign shutdown = !lines_enable &&
                      (state == ST_IDLE || state == ST_LOAD || state == ST_START);

    assign in_ready = (state == ST_LOAD || state == ST_START || state == ST_SEND) &&
                      (send || lines_enable) && !last_seen && (!hold_valid || consume);
    assign accept   = in_valid & in_ready;

    always_comb begin
        lane_data = '0;
        for (int i = 0; i < LANES_MAX; i++) begin
            if (send && hold_valid && mask[i]) begin
                lane_data[8*i +: 8] = hold_data[8*i +: 8];
            end
        end
    end

    assign lane_start_rqst = (state == ST_START) ? mask : '0;
    assign lane_fin_rqst   = (send && hold_valid && hold_last) ? mask : '0;
    assign lane_enable     = (state != ST_DISABLED);
    assign lane_mode_lp    = lp_mode;
    assign busy            = (state != ST_DISABLED) && (state != ST_IDLE);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_DISABLED;
            hold_data     <= '0;
            hold_last     <= 1'b0;
            hold_valid    <= 1'b0;
            last_seen     <= 1'b0;
            mask          <= '0;
            lp_mode       <= 1'b0;
            underflow_err <= 1'b0;
            sync_err      <= 1'b0;
        end else begin
            unique case (state)
                ST_DISABLED: if (lines_enable) begin
                    state         <= ST_IDLE;
                    underflow_err <= 1'b0;
                    sync_err      <= 1'b0;
                end
                ST_IDLE: begin
                    if (!lines_enable) begin
                        state <= ST_DISABLED;
                    end else if (in_valid) begin
                        state   <= ST_LOAD;
                        mask    <= mask_next;
                        lp_mode <= in_lp;
                    end
                end
                ST_LOAD: begin
                    if (!lines_enable) state <= ST_DISABLED;
                    else if (hold_valid) state <= ST_START;
                end
                ST_START: state <= lines_enable ? ST_SEND : ST_DISABLED;
                ST_SEND:  if (consume && hold_last) state <= ST_DRAIN;
                ST_DRAIN: if ((lane_active & mask) == '0) state <= ST_IDLE;
                default:  state <= ST_DISABLED;
            endcase

            if (shutdown || state == ST_IDLE) begin
                hold_valid <= 1'b0;
                last_seen  <= 1'b0;
            end else if (accept) begin
                hold_data  <= in_data;
                hold_last  <= in_last;
                hold_valid <= 1'b1;
                last_seen  <= last_seen | in_last;
            end else if (consume) begin
                hold_valid <= 1'b0;
            end

            if (send && lane_data_rqst[0] && !hold_valid) underflow_err <= 1'b1;
            if (send && ((lane_data_rqst & mask) != '0) && ((lane_data_rqst & mask) != mask)) begin
                sync_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dsi_lanes_distributor.sv
// tb/tb_dsi_lanes_distributor.sv - scoreboard bench for dsi_lanes_distributor
module tb_dsi_lanes_distributor;

    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic        lines_enable = 1'b0;
    logic [1:0]  lanes_number = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        in_last = 1'b0;
    logic        in_lp = 1'b0;
    logic        lane_enable;
    logic        lane_mode_lp;
    logic [3:0]  lane_start_rqst;
    logic [3:0]  lane_fin_rqst;
    logic [31:0] lane_data;
    logic [3:0]  lane_data_rqst = 4'h0;
    logic [3:0]  lane_active = 4'h0;
    logic        busy;
    logic        underflow_err;
    logic        sync_err;

    dsi_lanes_distributor #(.LANES_MAX(4)) dut (
        .clk_sys(clk_sys),
        .rst_n(rst_n),
        .lines_enable(lines_enable),
        .lanes_number(lanes_number),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .in_lp(in_lp),
        .lane_enable(lane_enable),
        .lane_mode_lp(lane_mode_lp),
        .lane_start_rqst(lane_start_rqst),
        .lane_fin_rqst(lane_fin_rqst),
        .lane_data(lane_data),
        .lane_data_rqst(lane_data_rqst),
        .lane_active(lane_active),
        .busy(busy),
        .underflow_err(underflow_err),
        .sync_err(sync_err)
    );

    always #5 clk_sys = ~clk_sys;

    int         checks = 0;
    int         errors = 0;
    logic [35:0] exp_q[$];
    logic [3:0]  start_q[$];
    bit          mon_en = 1'b1;
    logic [3:0]  rqst_pat = 4'h0;
    bit          rqst_on = 1'b0;
    int          drain_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural lanes: request a byte every cycle between start pulse and accepted fin.
    initial begin
        forever begin
            bit on_p, off_p;
            @(negedge clk_sys);
            on_p  = (lane_start_rqst != 4'h0);
            off_p = (lane_fin_rqst != 4'h0) && lane_data_rqst[0];
            @(posedge clk_sys);
            #1;
            if (!rst_n) begin
                rqst_on = 1'b0;
                drain_cnt = 0;
                lane_active = 4'h0;
            end else begin
                if (on_p) begin
                    rqst_on = 1'b1;
                    lane_active = 4'hF;
                end
                if (off_p) begin
                    rqst_on = 1'b0;
                    drain_cnt = 2;
                end else if (drain_cnt > 0) begin
                    drain_cnt--;
                    if (drain_cnt == 0) lane_active = 4'h0;
                end
            end
            lane_data_rqst = rqst_on ? rqst_pat : 4'h0;
        end
    end

    initial begin
        forever begin
            @(negedge clk_sys);
            if (mon_en && rst_n) begin
                if (lane_start_rqst != 4'h0) begin
                    if (start_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL start_unexpected: got 0x%0h expected none", lane_start_rqst);
                    end else begin
                        check("start_mask", 64'(lane_start_rqst), 64'(start_q.pop_front()));
                    end
                end
                if (lane_data_rqst[0]) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL beat_unexpected: got 0x%0h expected none", {lane_fin_rqst, lane_data});
                    end else begin
                        check("lane_beat", 64'({lane_fin_rqst, lane_data}), 64'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic last, input logic lp);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_lp    = lp;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk_sys);
            if (in_ready) begin
                @(posedge clk_sys);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: got no in_ready expected in_ready=1");
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk_sys);
            if (!busy) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0");
        end
    endtask

    task automatic toggle_enable();
        @(posedge clk_sys); #1;
        lines_enable = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        lines_enable = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("rst_status", 64'({in_ready, busy, lane_enable, lane_mode_lp, underflow_err, sync_err}), 64'h0);
        check("rst_lane_ctrl", 64'({lane_start_rqst, lane_fin_rqst}), 64'h0);
        check("rst_lane_data", 64'(lane_data), 64'h0);
        @(posedge clk_sys); #1;
        rst_n = 1'b1;
        lines_enable = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("idle_state", 64'({lane_enable, busy, in_ready}), 64'b100);

        // Four lanes, HS, three back-to-back beats.
        lanes_number = 2'd3; rqst_pat = 4'hF;
        start_q.push_back(4'hF);
        exp_q.push_back({4'h0, 32'h03020100});
        exp_q.push_back({4'h0, 32'h07060504});
        exp_q.push_back({4'hF, 32'h0B0A0908});
        send_beat(32'h03020100, 1'b0, 1'b0);
        send_beat(32'h07060504, 1'b0, 1'b0);
        send_beat(32'h0B0A0908, 1'b1, 1'b0);
        wait_idle();
        check("hs3_errors", 64'({underflow_err, sync_err, lane_mode_lp}), 64'h0);

        // One lane, LP, single beat.
        lanes_number = 2'd0; rqst_pat = 4'h1;
        start_q.push_back(4'h1);
        exp_q.push_back({4'h1, 32'h000000A5});
        send_beat(32'h000000A5, 1'b1, 1'b1);
        @(negedge clk_sys);
        check("lp_mode", 64'(lane_mode_lp), 64'h1);
        wait_idle();
        check("lp1_errors", 64'({underflow_err, sync_err}), 64'h0);

        // Lanes disagree on request: sync error.
        lanes_number = 2'd3; rqst_pat = 4'h3;
        start_q.push_back(4'hF);
        exp_q.push_back({4'hF, 32'h13121110});
        send_beat(32'h13121110, 1'b1, 1'b0);
        wait_idle();
        check("sync_set", 64'({underflow_err, sync_err}), 64'b01);
        @(posedge clk_sys); #1;
        lines_enable = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("sync_sticky_disabled", 64'({sync_err, lane_enable}), 64'b10);
        toggle_enable();
        @(negedge clk_sys);
        check("sync_cleared", 64'(sync_err), 64'h0);

        // Upstream stalls mid-packet while lane 0 keeps requesting.
        mon_en = 1'b0;
        lanes_number = 2'd1; rqst_pat = 4'h3;
        send_beat(32'h00002211, 1'b0, 1'b0);
        repeat (6) @(negedge clk_sys);
        check("underflow_set", 64'({underflow_err, busy}), 64'b11);
        send_beat(32'h00004433, 1'b1, 1'b0);
        wait_idle();
        check("underflow_sticky", 64'({underflow_err, sync_err}), 64'b10);
        toggle_enable();
        @(negedge clk_sys);
        check("underflow_cleared", 64'(underflow_err), 64'h0);
        mon_en = 1'b1;

        // Reset while a beat is held in SEND.
        lanes_number = 2'd3; rqst_pat = 4'h0;
        start_q.push_back(4'hF);
        send_beat(32'h33221100, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 32'h77665544; in_last = 1'b0;
        repeat (5) @(negedge clk_sys);
        check("pre_reset_send", 64'({busy, lane_data}), {31'h0, 1'b1, 32'h33221100});
        @(posedge clk_sys); #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk_sys);
        check("rst_mid_status", 64'({in_ready, busy, lane_enable, lane_mode_lp, underflow_err, sync_err}), 64'h0);
        check("rst_mid_lanes", 64'({lane_start_rqst, lane_fin_rqst, lane_data}), 64'h0);
        @(posedge clk_sys); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("post_reset_idle", 64'({lane_enable, busy, in_ready}), 64'b100);

        check("exp_q_drained", 64'(exp_q.size()), 64'h0);
        check("start_q_drained", 64'(start_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
